// File: rtl/multi_input_logic_gate_if.sv
// Control/status bundle for multi_input_logic_gate.
// The master drives the gate controls; the slave returns the result.
interface multi_input_logic_gate_if #(
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 8
);
  logic                  enable;
  logic [1:0]            mode;
  logic [NUM_INPUTS-1:0] gate_inputs;
  logic                  count_clear;
  logic                  logic_result;
  logic                  result_changed;
  logic [CNT_WIDTH-1:0]  change_count;

  modport master (
    output enable, mode, gate_inputs, count_clear,
    input  logic_result, result_changed, change_count
  );

  modport slave (
    input  enable, mode, gate_inputs, count_clear,
    output logic_result, result_changed, change_count
  );
endinterface

// File: rtl/multi_input_logic_gate.sv
// Synchronised, debounced N-input gate with selectable operator,
// registered result, change pulse and saturating change counter.
module multi_input_logic_gate #(
  parameter int NUM_INPUTS      = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input logic                  clk,
  input logic                  rst,
  multi_input_logic_gate_if.slave io
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_INPUTS-1:0] s1;
  logic [NUM_INPUTS-1:0] s2;
  logic [NUM_INPUTS-1:0] filt;
  logic [CW-1:0]         db_cnt [NUM_INPUTS];
  logic                  res_q;
  logic                  chg_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  red;
  logic                  differs;

  always_comb begin
    red = 1'b0;
    unique case (io.mode)
      2'b00: red = &filt;
      2'b01: red = |filt;
      2'b10: red = ^filt;
      2'b11: red = ~&filt;
    endcase
  end

  assign differs = io.enable && (red != res_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      filt  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++)
        db_cnt[i] <= '0;
      res_q <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1 <= io.gate_inputs;
      s2 <= s1;
      // A bit only flips after DEBOUNCE_CYCLES disagreeing samples
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (s2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      if (io.enable)
        res_q <= red;
      chg_q <= differs;
      if (io.count_clear)
        cnt_q <= '0;
      else if (differs && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign io.logic_result   = res_q;
  assign io.result_changed = chg_q;
  assign io.change_count   = cnt_q;

endmodule

// File: tb/tb_multi_input_logic_gate.sv
// Randomised and directed bench for multi_input_logic_gate with a
// behavioural model; a CNT_WIDTH=2 twin covers counter saturation.
module tb_multi_input_logic_gate;
  localparam int N = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_input_logic_gate_if #(.NUM_INPUTS(N), .CNT_WIDTH(8)) bus ();
  multi_input_logic_gate_if #(.NUM_INPUTS(N), .CNT_WIDTH(2)) bus2 ();

  assign bus2.enable      = bus.enable;
  assign bus2.mode        = bus.mode;
  assign bus2.gate_inputs = bus.gate_inputs;
  assign bus2.count_clear = bus.count_clear;

  multi_input_logic_gate #(
    .NUM_INPUTS(N), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .io(bus)
  );

  multi_input_logic_gate #(
    .NUM_INPUTS(N), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .rst(rst), .io(bus2)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  logic [N-1:0] m_s1 = '0;
  logic [N-1:0] m_s2 = '0;
  logic [N-1:0] m_f  = '0;
  int           m_run [N];
  logic         m_res = 1'b0;
  logic         m_chg = 1'b0;
  int           m_cnt = 0;
  int           m_cnt2 = 0;

  function automatic logic reduce(input logic [1:0] md,
                                  input logic [N-1:0] f);
    int ones;
    ones = $countones(f);
    case (md)
      2'd0:    return ones == N;
      2'd1:    return ones > 0;
      2'd2:    return (ones % 2) == 1;
      default: return ones != N;
    endcase
  endfunction

  task automatic model_edge();
    logic r;
    logic c;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_f = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_res = 0; m_chg = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    r = reduce(bus.mode, m_f);
    c = bus.enable && (r != m_res);
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] == m_f[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_f[i] = m_s2[i];
          m_run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.gate_inputs;
    if (bus.enable) m_res = r;
    m_chg = c;
    if (bus.count_clear) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (c) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("result", int'(bus.logic_result), int'(m_res));
    check("changed", int'(bus.result_changed), int'(m_chg));
    check("count", int'(bus.change_count), m_cnt);
    check("count2", int'(bus2.change_count), m_cnt2);
    check("result2", int'(bus2.logic_result), int'(m_res));
    if (bus.result_changed) pulses++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_rise(input string name, input int exp_edge);
    int lat;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (lat < 0 && bus.logic_result) lat = k;
    end
    check(name, lat, exp_edge);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_run[i] = 0;
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.mode = 2'b00;
    bus.gate_inputs = '0;
    bus.count_clear = 1'b0;
    #1;
    steps(3);
    check("rst_result", int'(bus.logic_result), 0);
    check("rst_changed", int'(bus.result_changed), 0);
    check("rst_count", int'(bus.change_count), 0);
    rst = 1'b0;
    step();
    check("post_rst_count", int'(bus.change_count), 0);

    bus.gate_inputs = 2'b11;
    pulses = 0;
    wait_rise("latency", 7);
    check("rise_pulses", pulses, 1);
    check("rise_count", int'(bus.change_count), 1);

    pulses = 0;
    bus.gate_inputs = 2'b10;
    steps(3);
    bus.gate_inputs = 2'b11;
    steps(10);
    check("glitch_result", int'(bus.logic_result), 1);
    check("glitch_pulses", pulses, 0);
    check("glitch_count", int'(bus.change_count), 1);

    bus.mode = 2'b10;
    step();
    check("xor_result", int'(bus.logic_result), 0);
    check("xor_count", int'(bus.change_count), 2);
    pulses = 0;
    bus.mode = 2'b11;
    steps(2);
    check("nand_result", int'(bus.logic_result), 0);
    check("nand_pulses", pulses, 0);
    bus.enable = 1'b0;
    bus.mode = 2'b01;
    steps(2);
    check("hold_result", int'(bus.logic_result), 0);
    bus.enable = 1'b1;
    step();
    check("or_result", int'(bus.logic_result), 1);
    check("or_count", int'(bus.change_count), 3);

    for (int t = 0; t < 5; t++) begin
      bus.mode = (t % 2 == 0) ? 2'b10 : 2'b00;
      step();
    end
    check("sat_count2", int'(bus2.change_count), 3);
    check("sat_count8", int'(bus.change_count), 8);
    bus.mode = 2'b00;
    bus.count_clear = 1'b1;
    step();
    bus.count_clear = 1'b0;
    check("clr_changed", int'(bus.result_changed), 1);
    check("clr_count2", int'(bus2.change_count), 0);
    check("clr_count8", int'(bus.change_count), 0);

    bus.gate_inputs = 2'b00;
    steps(10);
    check("fall_result", int'(bus.logic_result), 0);
    bus.gate_inputs = 2'b11;
    steps(4);
    rst = 1'b1;
    step();
    check("mid_rst_result", int'(bus.logic_result), 0);
    check("mid_rst_changed", int'(bus.result_changed), 0);
    check("mid_rst_count", int'(bus.change_count), 0);
    rst = 1'b0;
    wait_rise("rst_latency", 7);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) bus.gate_inputs = N'($urandom);
      if ($urandom_range(15) == 0) bus.mode = 2'($urandom);
      bus.enable = ($urandom_range(9) != 0);
      bus.count_clear = ($urandom_range(63) == 0);
      rst = ($urandom_range(299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
